// File: rtl/if_id_buf.sv
// ---------------------------------------------------------------------------
// if_id_buf -- fetch-to-decode pipeline buffer.
//
// A main register drives decode and a one-entry skid register absorbs the
// instruction that arrives in the same cycle decode stalls. Because of that
// spare entry, upstream ready depends only on state, and it can be a flop.
// flush_i squashes everything buffered or arriving, so decode sees a NOP.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   inst_i       instruction word from fetch
//   inst_addr_i  PC of inst_i
//   in_valid_i   fetch presents an instruction
//   in_ready_o   buffer can accept (registered, = ~skid_full)
//   inst_o       instruction to decode (NOP_INST when not valid)
//   inst_addr_o  PC of inst_o (0 when not valid)
//   out_valid_o  inst_o / inst_addr_o valid
//   out_ready_i  decode consumes this cycle
//   flush_i      squash all buffered and incoming instructions
// ---------------------------------------------------------------------------
module if_id_buf #(
   parameter int             DW       = 32,
   parameter logic [DW-1:0]  NOP_INST = 'h00000013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] inst_i,
   input  logic [DW-1:0] inst_addr_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic [DW-1:0] inst_o,
   output logic [DW-1:0] inst_addr_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   input  logic          flush_i
);

   typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] main_inst, main_addr, main_inst_nxt, main_addr_nxt;
   logic [DW-1:0] skid_inst, skid_addr, skid_inst_nxt, skid_addr_nxt;
   logic          out_valid_q, in_ready_q;
   logic          accept, issue;

   // Both handshakes use the registered outputs, so no input reaches an
   // output through logic.
   assign accept = in_valid_i & in_ready_q;
   assign issue  = out_valid_q & out_ready_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= EMPTY;
         main_inst   <= NOP_INST;
         main_addr   <= '0;
         skid_inst   <= '0;
         skid_addr   <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state       <= state_nxt;
         main_inst   <= main_inst_nxt;
         main_addr   <= main_addr_nxt;
         skid_inst   <= skid_inst_nxt;
         skid_addr   <= skid_addr_nxt;
         // Valid/ready flops are decoded from the next state so the ports
         // come straight off registers.
         out_valid_q <= (state_nxt != EMPTY);
         in_ready_q  <= (state_nxt != FULL2);
      end
   end

   always_comb begin
      state_nxt     = state;
      main_inst_nxt = main_inst;
      main_addr_nxt = main_addr;
      skid_inst_nxt = skid_inst;
      skid_addr_nxt = skid_addr;

      if (flush_i) begin
         // Flush wins over accept and issue.
         state_nxt     = EMPTY;
         main_inst_nxt = NOP_INST;
         main_addr_nxt = '0;
         skid_inst_nxt = '0;
         skid_addr_nxt = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_inst_nxt = inst_i;
                  main_addr_nxt = inst_addr_i;
                  state_nxt     = FULL1;
               end
            end
            FULL1: begin
               if (accept && issue) begin
                  main_inst_nxt = inst_i;
                  main_addr_nxt = inst_addr_i;
               end else if (accept) begin
                  skid_inst_nxt = inst_i;
                  skid_addr_nxt = inst_addr_i;
                  state_nxt     = FULL2;
               end else if (issue) begin
                  // The main register doubles as the output, so leaving
                  // it at NOP/0 keeps the idle output clean.
                  main_inst_nxt = NOP_INST;
                  main_addr_nxt = '0;
                  state_nxt     = EMPTY;
               end
            end
            FULL2: begin
               // in_ready_o is low here, so only an issue can move us.
               if (issue) begin
                  main_inst_nxt = skid_inst;
                  main_addr_nxt = skid_addr;
                  skid_inst_nxt = '0;
                  skid_addr_nxt = '0;
                  state_nxt     = FULL1;
               end
            end
            default: begin
               state_nxt     = EMPTY;
               main_inst_nxt = NOP_INST;
               main_addr_nxt = '0;
               skid_inst_nxt = '0;
               skid_addr_nxt = '0;
            end
         endcase
      end
   end

   assign inst_o      = main_inst;
   assign inst_addr_o = main_addr;
   assign out_valid_o = out_valid_q;
   assign in_ready_o  = in_ready_q;

endmodule

// File: tb/tb_if_id_buf.sv
// ---------------------------------------------------------------------------
// tb_if_id_buf -- self-checking bench for if_id_buf.
// A queue model holds accepted-but-not-issued instructions; every cycle the
// DUT outputs are compared against its head. Directed rows additionally
// carry explicit post-edge expectations.
// ---------------------------------------------------------------------------
module tb_if_id_buf;
   localparam int          DW  = 32;
   localparam logic [31:0] NOP = 32'h00000013;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] inst_i, inst_addr_i, inst_o, inst_addr_o;
   logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i, flush_i;

   if_id_buf #(.DW(DW), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .flush_i(flush_i)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [2*DW-1:0] q[$];   // {inst, addr}, head = next to issue

   typedef struct {
      logic        v;
      logic [31:0] inst, addr;
      logic        r, f;
      logic        ev, er;
      logic [31:0] einst, eaddr;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs with the model's view of the buffer.
   task automatic model_chk();
      logic [2*DW-1:0] h;
      chk("sb_ready", {31'd0, in_ready_o}, {31'd0, q.size() < 2});
      chk("sb_valid", {31'd0, out_valid_o}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
         h = q[0];
         chk("sb_inst", inst_o, h[2*DW-1:DW]);
         chk("sb_addr", inst_addr_o, h[DW-1:0]);
      end else begin
         chk("sb_inst_nop", inst_o, NOP);
         chk("sb_addr_zero", inst_addr_o, 32'd0);
      end
   endtask

   // Called at posedge+1: drive, check pre-edge, clock, update model.
   task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] a,
                        input logic r, input logic f);
      logic acc, iss;
      in_valid_i = v; inst_i = i; inst_addr_i = a; out_ready_i = r; flush_i = f;
      model_chk();
      acc = v && (q.size() < 2);
      iss = r && (q.size() > 0);
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (iss) void'(q.pop_front());
         if (acc) q.push_back({i, a});
      end
      #1;
   endtask

   task automatic add(input logic v, input logic [31:0] i, input logic [31:0] a,
                      input logic r, input logic f, input logic ev, input logic er,
                      input logic [31:0] ei, input logic [31:0] ea);
      vec_t t;
      t.v = v; t.inst = i; t.addr = a; t.r = r; t.f = f;
      t.ev = ev; t.er = er; t.einst = ei; t.eaddr = ea;
      tbl.push_back(t);
   endtask

   function automatic logic [31:0] mk(input logic [31:0] a);
      return 32'h1000_0000 | a;
   endfunction

   logic        rv, rr, rf, hold;
   logic [31:0] ri, ra, na;

   initial begin
      rst = 1'b0; in_valid_i = 0; inst_i = 0; inst_addr_i = 0;
      out_ready_i = 0; flush_i = 0;
      // Streaming 0,4,8 with one-cycle lag
      add(1, 32'h00500093, 0, 1, 0,  1, 1, 32'h00500093, 0);
      add(1, mk(4),  4, 1, 0,  1, 1, mk(4), 4);
      add(1, mk(8),  8, 1, 0,  1, 1, mk(8), 8);
      add(0, 0,      0, 1, 0,  0, 1, NOP,   0);
      // Stall into FULL2, then drain in order
      add(1, mk(0),  0, 1, 0,  1, 1, mk(0), 0);
      add(1, mk(4),  4, 0, 0,  1, 0, mk(0), 0);
      add(1, mk(8),  8, 0, 0,  1, 0, mk(0), 0);
      add(1, mk(8),  8, 1, 0,  1, 1, mk(4), 4);
      add(1, mk(8),  8, 1, 0,  1, 1, mk(8), 8);
      add(0, 0,      0, 1, 0,  0, 1, NOP,   0);
      // Flush from FULL2, then flush from FULL1 with a same-cycle accept
      add(1, mk(32'h40), 32'h40, 0, 0,  1, 1, mk(32'h40), 32'h40);
      add(1, mk(32'h44), 32'h44, 0, 0,  1, 0, mk(32'h40), 32'h40);
      add(1, mk(32'h48), 32'h48, 0, 1,  0, 1, NOP, 0);
      add(1, mk(32'h4c), 32'h4c, 1, 0,  1, 1, mk(32'h4c), 32'h4c);
      add(1, mk(32'h50), 32'h50, 0, 1,  0, 1, NOP, 0);
      add(0, 0,      0, 1, 0,  0, 1, NOP,   0);
      // FULL1 accept+issue 16 -> 20
      add(1, mk(16), 16, 1, 0,  1, 1, mk(16), 16);
      add(1, mk(20), 20, 1, 0,  1, 1, mk(20), 20);
      add(0, 0,      0, 1, 0,  0, 1, NOP,   0);

      // Reset state, held across an edge
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
      chk("rst_inst",  inst_o, NOP);
      chk("rst_addr",  inst_addr_o, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[k]) begin
         cycle(tbl[k].v, tbl[k].inst, tbl[k].addr, tbl[k].r, tbl[k].f);
         chk($sformatf("row%0d_valid", k), {31'd0, out_valid_o}, {31'd0, tbl[k].ev});
         chk($sformatf("row%0d_ready", k), {31'd0, in_ready_o},  {31'd0, tbl[k].er});
         chk($sformatf("row%0d_inst", k),  inst_o,      tbl[k].einst);
         chk($sformatf("row%0d_addr", k),  inst_addr_o, tbl[k].eaddr);
      end

      // Asynchronous reset while FULL2
      cycle(1, mk(32'h60), 32'h60, 0, 0);
      cycle(1, mk(32'h64), 32'h64, 0, 0);
      chk("pre_arst_ready", {31'd0, in_ready_o}, 32'd0);
      #2 rst = 1'b0;
      #1;
      q.delete();
      chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("arst_ready", {31'd0, in_ready_o}, 32'd1);
      chk("arst_inst",  inst_o, NOP);
      chk("arst_addr",  inst_addr_o, 32'd0);
      in_valid_i = 0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // Random traffic; upstream holds a refused instruction until taken
      hold = 0; na = 32'h1000; rv = 0; ri = 0; ra = 0;
      for (int c = 0; c < 10000; c++) begin
         if (!hold) begin
            rv = ($urandom_range(0, 3) != 0);
            ri = $urandom;
            ra = na;
            if (rv) na = na + 4;
         end
         rr = ($urandom_range(0, 3) != 0);
         rf = ($urandom_range(0, 24) == 0);
         hold = rv && (q.size() >= 2) && !rf;
         cycle(rv, ri, ra, rr, rf);
      end
      in_valid_i = 0;
      model_chk();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
